// File: rtl/uart_frame_ser_if.sv
// Frame handshake between the uart_tx frame builder and the serialiser.
// The frame builder drives frame and frame_valid; the serialiser answers with frame_ready.
interface uart_frame_ser_if #(
    parameter int FRAME_W = 11
);
    logic [FRAME_W-1:0] frame;
    logic               frame_valid;
    logic               frame_ready;

    modport master (output frame, output frame_valid, input  frame_ready);
    modport slave  (input  frame, input  frame_valid, output frame_ready);
endinterface

// File: rtl/uart_frame_ser.sv
// Shifts an accepted FRAME_W-bit frame onto txd, LSB first, holding each bit CLKS_PER_BIT clocks.
// Pulses done for one cycle after the last bit period; txd idles high.
module uart_frame_ser #(
    parameter int FRAME_W      = 11,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             ret,
    uart_frame_ser_if.slave  fin,
    output logic             txd,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FRAME_W);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(FRAME_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Bit 0 goes straight to txd on accept, so only the remaining bits are held here.
    state_t               state_q, state_d;
    logic [FRAME_W-2:0]   sr_q, sr_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]        baud_cnt_q, baud_cnt_d;
    logic                 txd_q, txd_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        txd_d      = txd_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fin.frame_valid && ready_q) begin
                    sr_d       = fin.frame[FRAME_W-1:1];
                    txd_d      = fin.frame[0];
                    bit_cnt_d  = '0;
                    baud_cnt_d = '0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        txd_d     = 1'b1;
                        done_d    = 1'b1;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        txd_d     = sr_q[0];
                        sr_d      = sr_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fin.frame_ready = ready_q;
    assign txd             = txd_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_uart_frame_ser.sv
// Bench for uart_frame_ser: two instances (11 bits x 4 clocks, 10 bits x 2 clocks) checked every cycle
// against a timeline model (elapsed cycles since accept / clocks per bit selects the expected bit).
module tb_uart_frame_ser;
    logic clk = 1'b0;
    logic ret = 1'b1;
    always #5 clk = ~clk;

    logic        vld [2];
    logic [10:0] fr  [2];
    logic        txd_w [2];
    logic        busy_w[2];
    logic        done_w[2];
    logic        rdy_w [2];

    uart_frame_ser_if #(.FRAME_W(11)) ifa ();
    uart_frame_ser_if #(.FRAME_W(10)) ifb ();
    assign ifa.frame       = fr[0];
    assign ifa.frame_valid = vld[0];
    assign ifb.frame       = fr[1][9:0];
    assign ifb.frame_valid = vld[1];
    assign rdy_w[0]        = ifa.frame_ready;
    assign rdy_w[1]        = ifb.frame_ready;

    uart_frame_ser #(.FRAME_W(11), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .ret(ret), .fin(ifa), .txd(txd_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    uart_frame_ser #(.FRAME_W(10), .CLKS_PER_BIT(2)) dut_b (
        .clk(clk), .ret(ret), .fin(ifb), .txd(txd_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fw(input int i);
        return (i == 0) ? 11 : 10;
    endfunction
    function automatic int cpb(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // Reference model: a frame is a timeline of fw*cpb cycles after its accept edge.
    bit          act[2];
    int          el [2];
    logic [10:0] fm [2];
    bit          dn [2];

    always @(posedge clk or negedge ret) begin
        if (!ret) begin
            for (int i = 0; i < 2; i++) begin
                act[i] <= 1'b0;
                el[i]  <= 0;
                dn[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act[i]) begin
                    if (el[i] + 1 == fw(i) * cpb(i)) begin
                        act[i] <= 1'b0;
                        dn[i]  <= 1'b1;
                    end else begin
                        el[i]  <= el[i] + 1;
                        dn[i]  <= 1'b0;
                    end
                end else begin
                    dn[i] <= 1'b0;
                    if (vld[i]) begin
                        act[i] <= 1'b1;
                        el[i]  <= 0;
                        fm[i]  <= fr[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic exp_txd;
            exp_txd = act[i] ? fm[i][el[i] / cpb(i)] : 1'b1;
            check($sformatf("u%0d_txd", i),   32'(txd_w[i]),  32'(exp_txd));
            check($sformatf("u%0d_busy", i),  32'(busy_w[i]), 32'(act[i]));
            check($sformatf("u%0d_ready", i), 32'(rdy_w[i]),  32'(!act[i]));
            check($sformatf("u%0d_done", i),  32'(done_w[i]), 32'(dn[i]));
        end
    end

    task automatic wait_done(input int i, output int n);
        n = 0;
        while (done_w[i] !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic async_reset();
        @(posedge clk); #2;
        ret = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d_rst_txd", i),   32'(txd_w[i]),  32'd1);
            check($sformatf("u%0d_rst_busy", i),  32'(busy_w[i]), 32'd0);
            check($sformatf("u%0d_rst_done", i),  32'(done_w[i]), 32'd0);
            check($sformatf("u%0d_rst_ready", i), 32'(rdy_w[i]),  32'd1);
        end
        @(posedge clk); #2;
        ret = 1'b1;
    endtask

    initial begin
        int n;
        vld[0] = 1'b1; vld[1] = 1'b1;
        fr[0] = 11'($urandom); fr[1] = 11'($urandom);
        #1 ret = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", 32'(txd_w[0]), 32'd1);
        check("rst_ready", 32'(rdy_w[0]), 32'd1);
        vld[0] = 1'b0;
        @(posedge clk); #2 ret = 1'b1;

        // single frame 0x4AA followed back-to-back by 0x001
        @(posedge clk); #1;
        fr[0] = 11'h4AA; vld[0] = 1'b1;
        @(posedge clk); #1;
        fr[0] = 11'h001;
        wait_done(0, n);
        $display("[TB] frame 4AA done after %0d cycles", n);
        check("a_done_latency", 32'(n), 32'd44);
        check("a_done_txd", 32'(txd_w[0]), 32'd1);
        @(posedge clk); #1;
        check("b2b_bit0", 32'(txd_w[0]), 32'd1);
        check("b2b_busy", 32'(busy_w[0]), 32'd1);

        // frame and valid wiggle while busy; the in-flight frame must not change
        repeat (8) @(posedge clk);
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            fr[0] = 11'($urandom); vld[0] = 1'($urandom);
        end
        vld[0] = 1'b0;
        wait_done(0, n);
        $display("[TB] frame 001 done, remaining %0d cycles", n);

        // mid-frame reset, then 0x7FE from a clean state
        @(posedge clk); #1;
        fr[0] = 11'($urandom); vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (15) @(posedge clk);
        async_reset();
        @(posedge clk); #1;
        fr[0] = 11'h7FE; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        wait_done(0, n);
        $display("[TB] frame 7FE after reset done after %0d cycles", n);
        check("a_post_rst_latency", 32'(n), 32'd44);

        // 10-bit x 2-clock instance: frame lasts 20 cycles
        vld[1] = 1'b0;
        n = 0;
        while (busy_w[1] !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_idle_timeout", 32'(n < 100), 32'd1);
        fr[1] = 11'($urandom); vld[1] = 1'b1;
        @(posedge clk); #1;
        vld[1] = 1'b0;
        wait_done(1, n);
        $display("[TB] 10-bit frame done after %0d cycles", n);
        check("b_done_latency", 32'(n), 32'd20);

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 2) == 0);
                fr[i]  = 11'($urandom);
            end
            if ($urandom_range(0, 599) == 0) begin
                $display("[TB] random reset at cycle %0d", c);
                async_reset();
            end
        end
        vld[0] = 1'b0; vld[1] = 1'b0;
        repeat (50) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
